// File: rtl/btt_pkg.sv
// Shared types and default constants for the branch target table.
package btt_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SWEEP = 1'b1
  } sweep_state_e;

  localparam int BTT_D_DEFAULT      = 10;
  localparam int BTT_A_DEFAULT      = 8;
  localparam int BTT_DEPTH_DEFAULT  = 32;
  localparam int BTT_DEFAULT_TARGET = 0;

  // Width of an index that just covers DEPTH entries (never below 1 bit).
  function automatic int btt_idx_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/btt_sweep_ctrl.sv
// Invalidate-sweep controller: walks every entry index once after reset or a clear request.
module btt_sweep_ctrl
  import btt_pkg::*;
#(
  parameter int DEPTH = BTT_DEPTH_DEFAULT,
  parameter int IW    = btt_idx_width(BTT_DEPTH_DEFAULT)
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          clear,
  output logic          busy,
  output logic          sweep_we,
  output logic [IW-1:0] sweep_idx
);

  localparam logic [IW-1:0] LAST_IDX = IW'(DEPTH - 1);

  sweep_state_e  state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      IDLE: begin
        if (clear) begin
          state_d = SWEEP;
          idx_d   = '0;
        end
      end
      SWEEP: begin
        // A clear arriving mid-sweep is ignored; the sweep simply runs on.
        if (idx_q == LAST_IDX) begin
          state_d = IDLE;
          idx_d   = '0;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      default: begin
        state_d = SWEEP;
        idx_d   = '0;
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= SWEEP;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  assign busy      = (state_q == SWEEP);
  assign sweep_we  = busy;
  assign sweep_idx = idx_q;

endmodule

// File: rtl/branch_target_table.sv
// Direct-indexed branch target table with a valid bit per entry, 1-cycle lookup
// and a sequential invalidate sweep in place of a storage reset.
module branch_target_table
  import btt_pkg::*;
#(
  parameter int             D              = BTT_D_DEFAULT,
  parameter int             A              = BTT_A_DEFAULT,
  parameter int             DEPTH          = BTT_DEPTH_DEFAULT,
  parameter logic [D-1:0]   DEFAULT_TARGET = D'(BTT_DEFAULT_TARGET)
) (
  input  logic         Clk,
  input  logic         Reset,
  input  logic         clear,
  input  logic         rd_en,
  input  logic [A-1:0] rd_addr,
  output logic [D-1:0] rd_target,
  output logic         rd_hit,
  output logic         rd_valid,
  input  logic         wr_en,
  input  logic [A-1:0] wr_addr,
  input  logic [D-1:0] wr_data,
  output logic         busy
);

  localparam int          IW      = btt_idx_width(DEPTH);
  localparam int          AW1     = A + 1;
  localparam logic [A:0]  DEPTH_W = AW1'(DEPTH);

  logic          sweep_we;
  logic [IW-1:0] sweep_idx;

  btt_sweep_ctrl #(
    .DEPTH (DEPTH),
    .IW    (IW)
  ) u_sweep_ctrl (
    .Clk       (Clk),
    .Reset     (Reset),
    .clear     (clear),
    .busy      (busy),
    .sweep_we  (sweep_we),
    .sweep_idx (sweep_idx)
  );

  logic [D-1:0] target_mem [DEPTH];
  logic         valid_mem  [DEPTH];

  logic          wr_in_range, rd_in_range, wr_accept;
  logic [IW-1:0] wr_idx, rd_idx, mem_idx;
  logic          mem_we, mem_valid;
  logic [D-1:0]  mem_data;

  assign wr_in_range = ({1'b0, wr_addr} < DEPTH_W);
  assign rd_in_range = ({1'b0, rd_addr} < DEPTH_W);
  assign wr_idx      = wr_addr[IW-1:0];
  assign rd_idx      = rd_addr[IW-1:0];
  // Clear in the same cycle beats a program request.
  assign wr_accept   = wr_en & ~busy & ~clear & ~Reset & wr_in_range;

  always_comb begin
    mem_we    = sweep_we | wr_accept;
    mem_idx   = wr_idx;
    mem_data  = wr_data;
    mem_valid = 1'b1;
    if (sweep_we) begin
      mem_idx   = sweep_idx;
      mem_data  = DEFAULT_TARGET;
      mem_valid = 1'b0;
    end
  end

  always_ff @(posedge Clk) begin
    if (mem_we) begin
      target_mem[mem_idx] <= mem_data;
      valid_mem[mem_idx]  <= mem_valid;
    end
  end

  logic [D-1:0] rd_target_q, rd_target_d;
  logic         rd_hit_q, rd_hit_d;
  logic         rd_valid_q, rd_valid_d;

  always_comb begin
    rd_valid_d  = rd_en;
    rd_target_d = rd_target_q;
    rd_hit_d    = rd_hit_q;
    if (rd_en) begin
      rd_target_d = DEFAULT_TARGET;
      rd_hit_d    = 1'b0;
      if (!busy && rd_in_range) begin
        if (wr_accept && (wr_idx == rd_idx)) begin
          rd_target_d = wr_data;
          rd_hit_d    = 1'b1;
        end else if (valid_mem[rd_idx]) begin
          rd_target_d = target_mem[rd_idx];
          rd_hit_d    = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      rd_valid_q  <= 1'b0;
      rd_hit_q    <= 1'b0;
      rd_target_q <= DEFAULT_TARGET;
    end else begin
      rd_valid_q  <= rd_valid_d;
      rd_hit_q    <= rd_hit_d;
      rd_target_q <= rd_target_d;
    end
  end

  assign rd_valid  = rd_valid_q;
  assign rd_hit    = rd_hit_q;
  assign rd_target = rd_target_q;

endmodule

// File: tb/tb_branch_target_table.sv
// Scoreboard bench for branch_target_table: a reference model predicts each lookup result.
module tb_branch_target_table;

  logic       Clk = 1'b0;
  logic       Reset, clear, rd_en, wr_en, rd_hit, rd_valid, busy;
  logic [7:0] rd_addr, wr_addr;
  logic [9:0] rd_target, wr_data;

  branch_target_table dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .clear     (clear),
    .rd_en     (rd_en),
    .rd_addr   (rd_addr),
    .rd_target (rd_target),
    .rd_hit    (rd_hit),
    .rd_valid  (rd_valid),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .busy      (busy)
  );

  always #5 Clk = ~Clk;

  typedef struct packed {
    logic [9:0] t;
    logic       h;
  } exp_t;

  exp_t       rd_q[$];
  logic [9:0] m_tgt[32];
  bit         m_val[32];
  int         sweep_cnt = 0;
  logic [9:0] last_t = '0;
  logic       last_h = 1'b0;
  int         n_checks = 0;
  int         n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick(input bit rst, input bit clr, input bit we, input logic [7:0] wa,
                      input logic [9:0] wd, input bit re, input logic [7:0] ra);
    exp_t e;
    bit   accept, busy_m;
    Reset = rst; clear = clr; wr_en = we; wr_addr = wa; wr_data = wd;
    rd_en = re; rd_addr = ra;
    busy_m = (sweep_cnt > 0);
    accept = !rst && !busy_m && !clr && we && (wa < 8'd32);
    if (re && !rst) begin
      e = '{t: 10'd0, h: 1'b0};
      if (!busy_m && ra < 8'd32) begin
        if (accept && wa == ra) e = '{t: wd, h: 1'b1};
        else if (m_val[ra[4:0]]) e = '{t: m_tgt[ra[4:0]], h: 1'b1};
      end
      rd_q.push_back(e);
    end
    @(posedge Clk);
    if (rst) begin
      sweep_cnt = 32;
      last_t = '0;
      last_h = 1'b0;
    end else begin
      if (busy_m) begin
        m_val[32 - sweep_cnt] = 1'b0;
        sweep_cnt--;
      end else if (clr) begin
        sweep_cnt = 32;
      end
      if (accept) begin
        m_tgt[wa[4:0]] = wd;
        m_val[wa[4:0]] = 1'b1;
      end
    end
    #1;
    check("busy", busy, sweep_cnt > 0);
    check("rd_valid", rd_valid, re && !rst);
    if (rd_valid) begin
      check("sb_depth", rd_q.size(), 1);
      if (rd_q.size() > 0) begin
        e = rd_q.pop_front();
        check("rd_target", rd_target, e.t);
        check("rd_hit", rd_hit, e.h);
        last_t = e.t;
        last_h = e.h;
      end
    end else begin
      check("hold_target", rd_target, last_t);
      check("hold_hit", rd_hit, last_h);
    end
  endtask

  task automatic idle();
    tick(0, 0, 0, 8'd0, 10'd0, 0, 8'd0);
  endtask

  task automatic write(input logic [7:0] wa, input logic [9:0] wd);
    tick(0, 0, 1, wa, wd, 0, 8'd0);
  endtask

  task automatic read(input logic [7:0] ra);
    tick(0, 0, 0, 8'd0, 10'd0, 1, ra);
  endtask

  task automatic count_busy(input string tag);
    int cnt = 0;
    while (busy && cnt < 100) begin
      if (cnt == 5) read(8'd5);
      else idle();
      cnt++;
    end
    check(tag, cnt, 32);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) begin
      m_val[i] = 1'b0;
      m_tgt[i] = '0;
    end
    // reset sweep; the lookup of index 5 happens mid-sweep
    tick(1, 0, 0, 8'd0, 10'd0, 1, 8'd3);
    tick(1, 0, 1, 8'd2, 10'd7, 0, 8'd0);
    count_busy("reset_sweep_len");
    check("s036_idx5_tgt", rd_target, 0);

    // program and read
    write(8'd3, 10'd285);
    read(8'd3);
    check("s037_tgt", rd_target, 285);
    check("s037_hit", rd_hit, 1);
    idle();

    // write-first
    tick(0, 0, 1, 8'd7, 10'd411, 1, 8'd7);
    check("s038_tgt", rd_target, 411);
    check("s038_hit", rd_hit, 1);

    // out of range: 40 would alias onto index 8 if the range guard were lost
    write(8'd40, 10'd100);
    read(8'd40);
    check("s039_hit", rd_hit, 0);
    read(8'd8);
    for (int i = 0; i < 10; i++) read(8'(i));

    // clear wins over a same-cycle write; clear mid-sweep is ignored
    write(8'd0, 10'd11);
    write(8'd1, 10'd22);
    write(8'd2, 10'd33);
    read(8'd1);
    tick(0, 1, 1, 8'd4, 10'd9, 0, 8'd0);
    for (int i = 0; i < 10; i++) idle();
    tick(0, 1, 1, 8'd5, 10'd55, 0, 8'd0);
    while (busy && sweep_cnt > 0) idle();
    for (int i = 0; i < 5; i++) begin
      read(8'(i));
      check("s040_hit", rd_hit, 0);
    end

    // reset at sweep index 20
    write(8'd6, 10'd66);
    tick(0, 1, 0, 8'd0, 10'd0, 0, 8'd0);
    for (int i = 0; i < 20; i++) idle();
    tick(1, 0, 0, 8'd0, 10'd0, 1, 8'd6);
    count_busy("reset_mid_sweep_len");
    read(8'd6);

    // random traffic
    for (int i = 0; i < 150; i++) begin
      tick(0, ($urandom_range(0, 39) == 0), $urandom_range(0, 1), 8'($urandom_range(0, 39)),
           10'($urandom), $urandom_range(0, 1), 8'($urandom_range(0, 39)));
    end
    // read back the whole table after settling
    while (busy && sweep_cnt > 0) idle();
    for (int i = 0; i < 40; i++) read(8'(i));
    idle();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
